ffstdp_sweep_ctrl: RTL and testbench

//  Sequences one FF-STDP training update over the full synapse array. On a training

---
 rtl/ffstdp_sweep_ctrl.sv | 117 +++++++++++
 tb/tb_ffstdp_sweep_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ffstdp_sweep_ctrl.sv
// FF-STDP training sweep sequencer: streams every synapse address through the weight
// SRAM read port and issues the matching write-back a fixed latency later.
module ffstdp_sweep_ctrl #(
  parameter int N_PRE  = 256,
  parameter int N_POST = 256,
  parameter int PRE_W  = 8,
  parameter int POST_W = 8,
  parameter int ADDR_W = PRE_W + POST_W,
  parameter int WB_LAT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              IS_TRAIN,
  input  logic              POS_LABEL,
  input  logic              HOLD,
  output logic              SRAM_RE,
  output logic [ADDR_W-1:0] SRAM_RADDR,
  output logic [PRE_W-1:0]  PRE_IDX,
  output logic [POST_W-1:0] POST_IDX,
  output logic              IS_POS,
  output logic              UPD_EN,
  output logic              SRAM_WE,
  output logic [ADDR_W-1:0] SRAM_WADDR,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(N_PRE - 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(N_POST - 1);

  state_t              state_reg;
  logic [PRE_W-1:0]    pre_reg;
  logic [POST_W-1:0]   post_reg;
  logic                is_pos_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [WB_LAT-1:0]   we_sr;
  logic [ADDR_W-1:0]   addr_sr [WB_LAT];
  logic                wb_pending;

  // HOLD gates the read in the same cycle so inference can take the port immediately.
  assign SRAM_RE    = (state_reg == S_ISSUE) && !HOLD;
  assign SRAM_RADDR = {post_reg, pre_reg};
  assign PRE_IDX    = pre_reg;
  assign POST_IDX   = post_reg;
  assign IS_POS     = is_pos_reg;
  assign BUSY       = busy_reg;
  assign DONE       = done_reg;
  assign SRAM_WE    = we_sr[WB_LAT-1];
  assign UPD_EN     = we_sr[WB_LAT-1];
  assign SRAM_WADDR = addr_sr[WB_LAT-1];

  // Pending ignores the final stage: it is being written this cycle, so DONE lands right after it.
  assign wb_pending = |(we_sr & ~(WB_LAT'(1) << (WB_LAT - 1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_sr <= '0;
      for (int i = 0; i < WB_LAT; i++) addr_sr[i] <= '0;
    end else begin
      we_sr[0]   <= SRAM_RE;
      addr_sr[0] <= SRAM_RADDR;
      for (int i = 1; i < WB_LAT; i++) begin
        we_sr[i]   <= we_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      pre_reg    <= '0;
      post_reg   <= '0;
      is_pos_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (START && IS_TRAIN) begin
            state_reg  <= S_ISSUE;
            busy_reg   <= 1'b1;
            is_pos_reg <= POS_LABEL;
            pre_reg    <= '0;
            post_reg   <= '0;
          end
        end
        S_ISSUE: begin
          if (!HOLD) begin
            if (pre_reg == PRE_LAST) begin
              pre_reg <= '0;
              if (post_reg == POST_LAST) state_reg <= S_DRAIN;
              else                       post_reg  <= post_reg + 1'b1;
            end else begin
              pre_reg <= pre_reg + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!wb_pending) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        S_DONE: state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffstdp_sweep_ctrl.sv
// Scoreboard bench for ffstdp_sweep_ctrl on a 4x3 synapse array with a 3-cycle write-back.
module tb_ffstdp_sweep_ctrl;
  localparam int N_PRE  = 4;
  localparam int N_POST = 3;
  localparam int PRE_W  = 4;
  localparam int POST_W = 4;
  localparam int ADDR_W = PRE_W + POST_W;
  localparam int WB_LAT = 3;
  localparam int N      = N_PRE * N_POST;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0, IS_TRAIN = 1'b0, POS_LABEL = 1'b0, HOLD = 1'b0;
  logic              SRAM_RE, SRAM_WE, UPD_EN, IS_POS, BUSY, DONE;
  logic [ADDR_W-1:0] SRAM_RADDR, SRAM_WADDR;
  logic [PRE_W-1:0]  PRE_IDX;
  logic [POST_W-1:0] POST_IDX;

  ffstdp_sweep_ctrl #(.N_PRE(N_PRE), .N_POST(N_POST), .PRE_W(PRE_W), .POST_W(POST_W),
                      .ADDR_W(ADDR_W), .WB_LAT(WB_LAT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IS_TRAIN(IS_TRAIN), .POS_LABEL(POS_LABEL),
    .HOLD(HOLD), .SRAM_RE(SRAM_RE), .SRAM_RADDR(SRAM_RADDR), .PRE_IDX(PRE_IDX),
    .POST_IDX(POST_IDX), .IS_POS(IS_POS), .UPD_EN(UPD_EN), .SRAM_WE(SRAM_WE),
    .SRAM_WADDR(SRAM_WADDR), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    int                pre;
    int                post;
  } ev_t;

  ev_t rq[$];
  ev_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  busy_lo = 1, busy_hi = 0;
  bit  pos_exp = 1'b0;
  bit  mon_on = 1'b0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected reads skip the HOLD window; writes trail by WB_LAT; DONE follows the last write.
  function automatic int push_exp(input int k, input int hold_off, input int hold_len);
    int  c = k + 1;
    int  n = 0;
    ev_t e;
    while (n < N) begin
      if (!(hold_len > 0 && c >= k + hold_off && c < k + hold_off + hold_len)) begin
        e.pre  = n % N_PRE;
        e.post = n / N_PRE;
        e.addr = ADDR_W'((e.post << PRE_W) | e.pre);
        e.cyc  = c;
        rq.push_back(e);
        e.cyc  = c + WB_LAT;
        wq.push_back(e);
        n++;
      end
      c++;
    end
    dq.push_back(c - 1 + WB_LAT + 1);
    return c - 1 + WB_LAT;
  endfunction

  task automatic sweep(input int hold_off, input int hold_len, input bit pos,
                       input int restart_off, input bit toggle_pos);
    int k, last_w;
    step();
    k = cyc;
    START = 1'b1; IS_TRAIN = 1'b1; POS_LABEL = pos; HOLD = 1'b0;
    last_w  = push_exp(k, hold_off, hold_len);
    busy_lo = k + 1;
    busy_hi = last_w;
    $display("sweep start k=%0d hold_off=%0d hold_len=%0d pos=%0d restart_off=%0d",
             k, hold_off, hold_len, pos, restart_off);
    while (cyc < last_w + 3) begin
      step();
      if (cyc == k + 1) pos_exp = pos;
      START = (restart_off > 0 && cyc == k + restart_off);
      HOLD  = (hold_len > 0 && cyc >= k + hold_off && cyc < k + hold_off + hold_len);
      if (toggle_pos) POS_LABEL = 1'($urandom_range(0, 1));
    end
    START = 1'b0; HOLD = 1'b0;
  endtask

  always @(negedge CLK) begin
    ev_t e;
    if (!RST && mon_on) begin
      if (SRAM_RE) begin
        if (rq.size() == 0) chk("re_extra", 1, 0);
        else begin
          e = rq.pop_front();
          $display("read  cyc=%0d addr=%0h exp_cyc=%0d exp_addr=%0h", cyc, SRAM_RADDR, e.cyc, e.addr);
          chk("re_cyc", cyc, e.cyc);
          chk("raddr", SRAM_RADDR, e.addr);
          chk("pre_idx", PRE_IDX, e.pre);
          chk("post_idx", POST_IDX, e.post);
        end
      end
      if (SRAM_WE || UPD_EN) begin
        chk("we", SRAM_WE, 1);
        chk("upd_en", UPD_EN, 1);
        if (wq.size() == 0) chk("we_extra", 1, 0);
        else begin
          e = wq.pop_front();
          $display("write cyc=%0d addr=%0h exp_cyc=%0d exp_addr=%0h", cyc, SRAM_WADDR, e.cyc, e.addr);
          chk("we_cyc", cyc, e.cyc);
          chk("waddr", SRAM_WADDR, e.addr);
        end
      end
      if (DONE) begin
        if (dq.size() == 0) chk("done_extra", 1, 0);
        else begin
          $display("done  cyc=%0d exp_cyc=%0d", cyc, dq[0]);
          chk("done_cyc", cyc, dq.pop_front());
        end
      end
      chk("busy", BUSY, (cyc >= busy_lo && cyc <= busy_hi));
      chk("is_pos", IS_POS, pos_exp);
    end
  end

  initial begin
    int k;
    repeat (3) step();
    chk("rst_re", SRAM_RE, 0);
    chk("rst_we", SRAM_WE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_is_pos", IS_POS, 0);
    chk("rst_raddr", SRAM_RADDR, 0);
    chk("rst_waddr", SRAM_WADDR, 0);
    RST = 1'b0;
    mon_on = 1'b1;
    repeat (4) step();

    // T1 plain sweep
    sweep(0, 0, 1'b0, 0, 1'b0);

    // T2 START without IS_TRAIN must do nothing
    step();
    START = 1'b1; IS_TRAIN = 1'b0; POS_LABEL = 1'b1;
    step();
    START = 1'b0;
    repeat (40) step();

    // T3 HOLD for two cycles starting 3 cycles after START
    sweep(3, 2, 1'b0, 0, 1'b0);

    // T4 second START mid-sweep ignored
    sweep(0, 0, 1'b0, 5, 1'b0);

    // T5 async reset mid-sweep
    step();
    k = cyc;
    START = 1'b1; IS_TRAIN = 1'b1; POS_LABEL = 1'b1;
    void'(push_exp(k, 0, 0));
    busy_lo = k + 1;
    busy_hi = k + N + WB_LAT;
    while (cyc < k + 8) begin
      step();
      START = 1'b0;
      if (cyc == k + 1) pos_exp = 1'b1;
    end
    RST = 1'b1;
    #1;
    chk("arst_re", SRAM_RE, 0);
    chk("arst_we", SRAM_WE, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_is_pos", IS_POS, 0);
    $display("reset asserted cyc=%0d re=%0d we=%0d busy=%0d", cyc, SRAM_RE, SRAM_WE, BUSY);
    rq.delete(); wq.delete(); dq.delete();
    pos_exp = 1'b0; busy_lo = 1; busy_hi = 0;
    step();
    step();
    RST = 1'b0;
    repeat (10) step();
    sweep(0, 0, 1'b0, 0, 1'b0);

    // T6 IS_POS latched at START despite POS_LABEL toggling
    sweep(0, 0, 1'b1, 0, 1'b1);
    POS_LABEL = 1'b0;
    repeat (6) step();
    sweep(0, 0, 1'b0, 0, 1'b1);

    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
